// File: rtl/shadow_copy_sequencer.sv
// rtl/shadow_copy_sequencer.sv - copies ROM[START_ADDR..END_ADDR] into RAM while holding the CPU in reset.
// Optional read-back verify is compiled in with SHADOW_VERIFY_EN.
module shadow_copy_sequencer #(
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic [15:0] END_ADDR   = 16'h7FFF
) (
  input  logic        CopyClock,
  input  logic        Reset,
  input  logic        Start,
  output logic [15:0] Addr,
  input  logic [7:0]  RomData,
  output logic        RomOE,
  output logic [7:0]  RamData,
  output logic        RamWE,
  input  logic [7:0]  RamRdData,
  output logic        RamOE,
  output logic        ResetReq,
  output logic        Done,
  output logic        VerifyErr
);

`ifdef SHADOW_VERIFY_EN
  typedef enum logic [2:0] {INIT, READ, WRITE, VERIFY, DONE} state_t;
`else
  typedef enum logic [2:0] {INIT, READ, WRITE, DONE} state_t;
`endif

  state_t      state, state_nxt;
  logic [15:0] ptr;
  logic [7:0]  dreg;
  logic        last_byte;

  // Compare before incrementing so END_ADDR=16'hFFFF never wraps.
  assign last_byte = (ptr == END_ADDR);

`ifdef SHADOW_VERIFY_EN
  logic verr;
  assign VerifyErr = verr & ~Reset;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^RamRdData;
  assign VerifyErr      = 1'b0;
`endif

  always_ff @(posedge CopyClock) begin
    if (Reset) begin
      state <= INIT;
      ptr   <= START_ADDR;
      dreg  <= 8'h00;
`ifdef SHADOW_VERIFY_EN
      verr  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        INIT:  ptr  <= START_ADDR;
        READ:  dreg <= RomData;
`ifdef SHADOW_VERIFY_EN
        VERIFY: begin
          if (RamRdData != dreg) verr <= 1'b1;
          if (!last_byte) ptr <= ptr + 16'd1;
        end
`else
        WRITE: if (!last_byte) ptr <= ptr + 16'd1;
`endif
        DONE: if (Start) begin
          ptr <= START_ADDR;
`ifdef SHADOW_VERIFY_EN
          verr <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    Addr      = ptr;
    RamData   = dreg;
    RomOE     = 1'b0;
    RamWE     = 1'b0;
    RamOE     = 1'b0;
    ResetReq  = 1'b1;
    Done      = 1'b0;
    case (state)
      INIT: state_nxt = READ;
      READ: begin
        RomOE     = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        RamWE = 1'b1;
`ifdef SHADOW_VERIFY_EN
        state_nxt = VERIFY;
`else
        state_nxt = last_byte ? DONE : READ;
`endif
      end
`ifdef SHADOW_VERIFY_EN
      VERIFY: begin
        RamOE     = 1'b1;
        state_nxt = last_byte ? DONE : READ;
      end
`endif
      DONE: begin
        ResetReq = 1'b0;
        Done     = 1'b1;
        if (Start) state_nxt = READ;
      end
      default: state_nxt = INIT;
    endcase
    // Reset masks the outputs in the same cycle so an in-flight write is dropped.
    if (Reset) begin
      state_nxt = INIT;
      Addr      = START_ADDR;
      RamData   = 8'h00;
      RomOE     = 1'b0;
      RamWE     = 1'b0;
      RamOE     = 1'b0;
      ResetReq  = 1'b1;
      Done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_shadow_copy_sequencer.sv
// tb/tb_shadow_copy_sequencer.sv - directed bench for shadow_copy_sequencer (with or without SHADOW_VERIFY_EN).
module tb_shadow_copy_sequencer;

`ifdef SHADOW_VERIFY_EN
  localparam int K = 3;
`else
  localparam int K = 2;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, start_a = 1'b0;
  logic [15:0] addr_a;
  logic [7:0]  rom_a, data_a, rd_a;
  logic        romoe_a, we_a, ramoe_a, rreq_a, done_a, verr_a;

  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [15:0] addr_b;
  logic [7:0]  rom_b, data_b, rd_b;
  logic        romoe_b, we_b, ramoe_b, rreq_b, done_b, verr_b;

  logic [7:0]  ram_a [4];
  logic [7:0]  ram_b = 8'h00;
  logic        force_err = 1'b0;

  shadow_copy_sequencer #(.START_ADDR(16'h0000), .END_ADDR(16'h0003)) u_a (
    .CopyClock(clk), .Reset(rst_a), .Start(start_a), .Addr(addr_a), .RomData(rom_a),
    .RomOE(romoe_a), .RamData(data_a), .RamWE(we_a), .RamRdData(rd_a), .RamOE(ramoe_a),
    .ResetReq(rreq_a), .Done(done_a), .VerifyErr(verr_a));

  shadow_copy_sequencer #(.START_ADDR(16'hFFFF), .END_ADDR(16'hFFFF)) u_b (
    .CopyClock(clk), .Reset(rst_b), .Start(start_b), .Addr(addr_b), .RomData(rom_b),
    .RomOE(romoe_b), .RamData(data_b), .RamWE(we_b), .RamRdData(rd_b), .RamOE(ramoe_b),
    .ResetReq(rreq_b), .Done(done_b), .VerifyErr(verr_b));

  always_comb begin
    case (addr_a)
      16'h0000: rom_a = 8'h11;
      16'h0001: rom_a = 8'h22;
      16'h0002: rom_a = 8'h33;
      16'h0003: rom_a = 8'h44;
      default:  rom_a = 8'h00;
    endcase
  end
  assign rom_b = (addr_b == 16'hFFFF) ? 8'hA5 : 8'h00;
  assign rd_a  = (force_err && addr_a == 16'h0001) ? 8'h00 : ram_a[addr_a[1:0]];
  assign rd_b  = ram_b;

  always @(posedge clk) begin
    if (we_a) ram_a[addr_a[1:0]] <= data_a;
    if (we_b) ram_b <= data_b;
  end

  logic [15:0] la_addr[$], lb_addr[$];
  logic [7:0]  la_data[$], lb_data[$];
  int excl_bad = 0, b_addr_zero = 0, we_in_rst = 0, ramoe_seen = 0;

  always @(negedge clk) begin
    if (we_a) begin la_addr.push_back(addr_a); la_data.push_back(data_a); end
    if (we_b) begin lb_addr.push_back(addr_b); lb_data.push_back(data_b); end
    if (we_a && rst_a) we_in_rst++;
    if ($countones({romoe_a, we_a, ramoe_a}) > 1) excl_bad++;
    if ($countones({romoe_b, we_b, ramoe_b}) > 1) excl_bad++;
    if (addr_b == 16'h0000) b_addr_zero++;
    if (ramoe_a || ramoe_b) ramoe_seen++;
  end

  int n_pass = 0, n_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_done_a(input string tag);
    int n = 0;
    while (!done_a && n < 200) begin step(); n++; end
    check(tag, done_a, 1);
  endtask

  task automatic check_log_a(input string tag);
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    check({tag, "_count"}, la_addr.size(), 4);
    if (la_addr.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_addr%0d", tag, i), la_addr[i], i);
        check($sformatf("%s_data%0d", tag, i), la_data[i], exp_d[i]);
      end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ram_a[i] = 8'h00;

    // basic copy 0..3
    step(); step();
    check("rst_addr", addr_a, 16'h0000);
    check("rst_data", data_a, 8'h00);
    check("rst_strobes", {romoe_a, we_a, ramoe_a}, 3'b000);
    check("rst_rreq", rreq_a, 1);
    check("rst_done", done_a, 0);
    check("rst_verr", verr_a, 0);
    rst_a = 1'b0;
    for (int e = 1; e <= 1 + K * 4; e++) begin
      step();
      if (e == K * 4) begin
        check("pre_done", done_a, 0);
        check("pre_rreq", rreq_a, 1);
      end
      if (e == K * 4 + 1) begin
        check("done_edge", done_a, 1);
        check("rreq_edge", rreq_a, 0);
      end
    end
    check_log_a("copy1");

    // single byte at FFFF
    step();
    check("b_rst_addr", addr_b, 16'hFFFF);
    rst_b = 1'b0;
    for (int e = 1; e <= 1 + K; e++) begin
      step();
      if (e == K) check("b_pre_done", done_b, 0);
    end
    check("b_done", done_b, 1);
    check("b_count", lb_addr.size(), 1);
    if (lb_addr.size() == 1) begin
      check("b_addr", lb_addr[0], 16'hFFFF);
      check("b_data", lb_data[0], 8'hA5);
    end
    repeat (5) step();
    check("b_done_hold", done_b, 1);
    check("b_addr_hold", addr_b, 16'hFFFF);

    // reset mid-copy while writing address 2
    rst_a = 1'b1; step(); rst_a = 1'b0;
    begin
      int n = 0;
      while (!(we_a && addr_a == 16'h0002) && n < 50) begin step(); n++; end
      check("found_wr2", we_a && addr_a == 16'h0002, 1);
    end
    rst_a = 1'b1;
    #1;
    check("abort_we", we_a, 0);
    check("abort_addr", addr_a, 16'h0000);
    check("abort_rreq", rreq_a, 1);
    step();
    rst_a = 1'b0;
    #1;
    check("init_romoe", romoe_a, 0);
    step();
    check("restart_romoe", romoe_a, 1);
    check("restart_addr", addr_a, 16'h0000);

    // Start in READ is ignored
    start_a = 1'b1; step(); start_a = 1'b0;
    check("ign_we", we_a, 1);
    check("ign_addr", addr_a, 16'h0000);
    run_done_a("ign_done");

    // Start in DONE recopies
    la_addr.delete(); la_data.delete();
    for (int i = 0; i < 4; i++) ram_a[i] = 8'h00;
    start_a = 1'b1; step(); start_a = 1'b0;
    check("re_rreq", rreq_a, 1);
    check("re_done", done_a, 0);
    check("re_romoe", romoe_a, 1);
    check("re_addr", addr_a, 16'h0000);
    run_done_a("re_done_end");
    check_log_a("copy2");

`ifdef SHADOW_VERIFY_EN
    force_err = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;
    begin
      int n = 0;
      while (!(ramoe_a && addr_a == 16'h0001) && n < 50) begin step(); n++; end
      check("found_ver1", ramoe_a && addr_a == 16'h0001, 1);
    end
    check("verr_before", verr_a, 0);
    step();
    check("verr_set", verr_a, 1);
    run_done_a("ver_done");
    check("verr_at_done", verr_a, 1);
    force_err = 1'b0;
    start_a = 1'b1; step(); start_a = 1'b0;
    check("verr_clear", verr_a, 0);
    run_done_a("ver_done2");
    check("verr_clean_run", verr_a, 0);
`else
    check("no_ramoe", ramoe_seen, 0);
    check("no_verr", verr_a | verr_b, 0);
`endif

    check("exclusive", excl_bad, 0);
    check("b_addr_never0", b_addr_zero, 0);
    check("we_in_reset", we_in_rst, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shadow_copy_sequencer.md
SHADOW_COPY_SEQUENCER -- requirements
Module: shadow_copy_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter START_ADDR, default 16'h0000, SHALL set the first source/destination address copied.
REQ-003 Parameter END_ADDR, default 16'h7FFF, SHALL set the last address copied, inclusive; START_ADDR <= END_ADDR SHALL hold.
REQ-004 Port CopyClock SHALL be an input, 1 bit, the sole clock; all state SHALL update on its rising edge.
REQ-005 Port Reset SHALL be an input, 1 bit, synchronous active-high reset.
REQ-006 Port Start SHALL be an input, 1 bit, a request to re-run the copy; it SHALL be sampled only in DONE.
REQ-007 Port Addr SHALL be an output, 16 bits, the shared address for ROM read and RAM write.
REQ-008 Port RomData SHALL be an input, 8 bits, the ROM read data, valid in the cycle RomOE is high.
REQ-009 Port RomOE SHALL be an output, 1 bit, the ROM output enable.
REQ-010 Port RamData SHALL be an output, 8 bits, the RAM write data.
REQ-011 Port RamWE SHALL be an output, 1 bit, the RAM write strobe, one cycle per byte.
REQ-012 Port RamRdData SHALL be an input, 8 bits, the RAM read-back data; it SHALL be ignored without SHADOW_VERIFY_EN.
REQ-013 Port RamOE SHALL be an output, 1 bit, the RAM read enable for verify.
REQ-014 Port ResetReq SHALL be an output, 1 bit, holding the CPU in reset while high.
REQ-015 Port Done SHALL be an output, 1 bit, high when the shadow copy is complete.
REQ-016 Port VerifyErr SHALL be an output, 1 bit, a sticky verify-mismatch flag.

Function
REQ-017 The FSM SHALL have states INIT, READ, WRITE, VERIFY and DONE, with a 16-bit pointer ptr and an 8-bit data register dreg.
REQ-018 INIT SHALL go to READ on the first edge with Reset low, loading ptr=START_ADDR.
REQ-019 In READ: Addr=ptr and RomOE=1; at the edge, dreg<=RomData and the FSM SHALL go to WRITE.
REQ-020 In WRITE: Addr=ptr, RamData=dreg and RamWE=1; the next state SHALL be VERIFY if SHADOW_VERIFY_EN, else the last-byte check.
REQ-021 Last-byte check: if ptr==END_ADDR the FSM SHALL go to DONE, else ptr<=ptr+1 and go to READ.
REQ-022 The comparison SHALL precede the increment, so END_ADDR=16'hFFFF SHALL terminate with no wrap to 0.
REQ-023 Copy latency SHALL be 2 cycles/byte (3 with verify), giving DONE exactly 1+k*(END_ADDR-START_ADDR+1) edges after Reset falls, where k=2 (3).
REQ-024 ResetReq SHALL be 1 in every state except DONE; Done SHALL be 1 only in DONE.
REQ-025 RomOE, RamWE and RamOE SHALL be mutually exclusive, with at most one high in any cycle.
REQ-026 Start in DONE SHALL cause ptr<=START_ADDR and a transition to READ (ResetReq re-asserts next cycle); VerifyErr SHALL be cleared.
REQ-027 Start outside DONE SHALL be ignored; Reset SHALL take priority over Start in the same cycle.
REQ-028 Outside WRITE, RamData SHALL hold dreg and RamWE SHALL be 0; outside READ and WRITE (and VERIFY), Addr SHALL hold ptr.

Reset
REQ-029 Reset high SHALL force INIT, ptr=START_ADDR, dreg=0 and VerifyErr=0.
REQ-030 While Reset is high, outputs SHALL be: Addr=START_ADDR, RamData=0, RomOE=0, RamWE=0, RamOE=0, ResetReq=1, Done=0, VerifyErr=0.
REQ-031 Reset asserted mid-copy SHALL abort the copy within the same edge with no further RamWE, and the copy SHALL restart from START_ADDR.

Configuration
REQ-032 When macro SHADOW_VERIFY_EN is defined, VERIFY SHALL be compiled in: Addr=ptr, RamOE=1, and RamRdData!=dreg SHALL set VerifyErr (sticky until Reset/Start); the FSM SHALL then perform the last-byte check.
REQ-033 When SHADOW_VERIFY_EN is undefined, VERIFY SHALL be absent, RamOE and VerifyErr SHALL be tied 0, and RamRdData SHALL be unused.

Verification
REQ-034 The bench SHALL cover: START=16'h0000, END=16'h0003, ROM={11,22,33,44}, no verify -> RamWE at addresses 0..3 with data 11,22,33,44, and Done/ResetReq toggling on edge 9 after Reset falls.
REQ-035 The bench SHALL cover: START=END=16'hFFFF, ROM[FFFF]=A5 -> a single write of A5 at FFFF, then DONE with Addr never 0000.
REQ-036 The bench SHALL cover: Reset pulsed while ptr=0002 -> no RamWE during Reset, and the next READ at START_ADDR.
REQ-037 The bench SHALL cover: Start pulsed in READ (ignored), then Start in DONE -> full recopy, ResetReq high again from the next cycle.
REQ-038 The bench SHALL cover, with SHADOW_VERIFY_EN: RamRdData forced to 00 at address 0001 with ROM=22 -> VerifyErr=1 from the VERIFY edge, persisting to DONE and clearing on Start.
REQ-039 The bench SHALL cover: all cycles of every scenario -> RomOE+RamWE+RamOE <= 1.
